// File: rtl/b_stream_rx.sv
// Receive side of the coprocessor burst stream. It writes one frame of words to a local
// memory port and checks the transmitter's s_last against locally recomputed burst boundaries.
module b_stream_rx #(
    parameter int SIZEBURST = 8,
    parameter int SIZECOUNT = 12,
    parameter int DATA_W    = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SIZECOUNT-1:0] size,
    input  logic [SIZEBURST-1:0] sizeburst,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 wr_en,
    output logic [SIZECOUNT-1:0] wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 endburst,
    output logic                 done,
    output logic                 busy,
    output logic                 err_last,
    output logic                 err_cfg
);

    localparam int CW = SIZECOUNT + 1;

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t               state_q, state_d;
    logic [SIZECOUNT-1:0] cnt_q, cnt_d;
    logic [SIZECOUNT-1:0] size_q, size_d;
    logic [SIZEBURST-1:0] sb_q, sb_d;
    logic                 wr_en_q, wr_en_d;
    logic [SIZECOUNT-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic                 endburst_q, endburst_d;
    logic                 err_last_q, err_last_d;
    logic                 err_cfg_q, err_cfg_d;

    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] burst_mask;
    logic          last_word;
    logic          exp_last;
    logic          cfg_bad;

    // The extra bit keeps cnt+1 exact on the final word of a maximum-size frame.
    assign cnt_inc    = {1'b0, cnt_q} + CW'(1);
    assign burst_mask = (CW'(1) << sb_q) - CW'(1);
    assign last_word  = (cnt_inc == {1'b0, size_q});
    assign exp_last   = ((cnt_inc & burst_mask) == '0) || last_word;
    assign cfg_bad    = (32'(sizeburst) > SIZEBURST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            size_q     <= '0;
            sb_q       <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            endburst_q <= 1'b0;
            err_last_q <= 1'b0;
            err_cfg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            sb_q       <= sb_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            endburst_q <= endburst_d;
            err_last_q <= err_last_d;
            err_cfg_q  <= err_cfg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        sb_d       = sb_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        endburst_d = 1'b0;
        err_last_d = err_last_q;
        err_cfg_d  = err_cfg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        err_cfg_d = 1'b1;
                    end else begin
                        err_cfg_d  = 1'b0;
                        err_last_d = 1'b0;
                        cnt_d      = '0;
                        size_d     = size;
                        sb_d       = sizeburst;
                        state_d    = (size == '0) ? DONE : RECV;
                    end
                end
            end
            RECV: begin
                // s_ready is high for every cycle in RECV, so s_valid alone marks a beat.
                if (s_valid) begin
                    cnt_d      = cnt_q + SIZECOUNT'(1);
                    wr_en_d    = 1'b1;
                    wr_addr_d  = cnt_q;
                    wr_data_d  = s_data;
                    endburst_d = exp_last;
                    if (s_last != exp_last) err_last_d = 1'b1;
                    if (last_word) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign s_ready  = (state_q == RECV);
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign endburst = endburst_q;
    assign err_last = err_last_q;
    assign err_cfg  = err_cfg_q;

endmodule
